// File: rtl/sumador_multipalabra_ctrl.sv
// Multi-word adder controller: drives one 32-bit adder word by word, LSW first,
// chaining the carry through a register. Optional subtraction with `SUMA_RESTA_EN.

module sumador32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_suma,
    output logic        o_cout
);
    assign {o_cout, o_suma} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

module sumador_multipalabra_ctrl #(
    parameter int PALABRAS = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic [32*PALABRAS-1:0]  i_datoA,
    input  logic [32*PALABRAS-1:0]  i_datoB,
    input  logic                    i_carryIn,
`ifdef SUMA_RESTA_EN
    input  logic                    i_resta,
`endif
    output logic                    o_ocupado,
    output logic                    o_listo,
    output logic [32*PALABRAS-1:0]  o_resultado,
    output logic                    o_carryOut,
    output logic                    o_desborde
);
    localparam int IW = (PALABRAS > 1) ? $clog2(PALABRAS) : 1;
    localparam logic [IW-1:0] ULTIMO = IW'(PALABRAS - 1);

    typedef enum logic [1:0] {INACTIVO, SUMANDO, LISTO} estado_t;

    estado_t                     r_estado, w_sig_estado;
    logic [PALABRAS-1:0][31:0]   r_a, r_b, r_res;
    logic [IW-1:0]               r_idx;
    logic                        r_carry, r_carry_out, r_desborde;
    logic                        w_acepta, w_ultimo, w_cout;
    logic [31:0]                 w_a, w_b_ef, w_suma;

`ifdef SUMA_RESTA_EN
    logic r_resta;
    assign w_b_ef = r_b[r_idx] ^ {32{r_resta}};
`else
    assign w_b_ef = r_b[r_idx];
`endif

    assign w_a      = r_a[r_idx];
    assign w_acepta = (r_estado == INACTIVO) && i_start;
    assign w_ultimo = (r_idx == ULTIMO);

    sumador32bit u_sumador (
        .i_a    (w_a),
        .i_b    (w_b_ef),
        .i_cin  (r_carry),
        .o_suma (w_suma),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_estado <= INACTIVO;
        else       r_estado <= w_sig_estado;
    end

    always_comb begin
        w_sig_estado = r_estado;
        case (r_estado)
            INACTIVO: if (i_start)  w_sig_estado = SUMANDO;
            SUMANDO:  if (w_ultimo) w_sig_estado = LISTO;
            LISTO:                  w_sig_estado = INACTIVO;
            default:                w_sig_estado = INACTIVO;
        endcase
    end

    always_comb begin
        o_ocupado = 1'b0;
        o_listo   = 1'b0;
        case (r_estado)
            SUMANDO: o_ocupado = 1'b1;
            LISTO: begin
                o_ocupado = 1'b1;
                o_listo   = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: operand latch on accept, one word per SUMANDO cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_desborde  <= 1'b0;
`ifdef SUMA_RESTA_EN
            r_resta     <= 1'b0;
`endif
        end else if (w_acepta) begin
            r_a         <= i_datoA;
            r_b         <= i_datoB;
            r_res       <= '0;
            r_idx       <= '0;
            r_carry_out <= 1'b0;
            r_desborde  <= 1'b0;
`ifdef SUMA_RESTA_EN
            r_resta     <= i_resta;
            r_carry     <= i_carryIn | i_resta;
`else
            r_carry     <= i_carryIn;
`endif
        end else if (r_estado == SUMANDO) begin
            r_res[r_idx] <= w_suma;
            r_carry      <= w_cout;
            if (w_ultimo) begin
                r_idx       <= '0;
                r_carry_out <= w_cout;
                // Signed overflow judged on the effective (possibly inverted) B.
                r_desborde  <= (w_a[31] == w_b_ef[31]) && (w_suma[31] != w_a[31]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_resultado = r_res;
    assign o_carryOut  = r_carry_out;
    assign o_desborde  = r_desborde;
endmodule
